cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run-control sequencer for the single-cycle CPU core (sccomp_dataflow datapath).
- Holds the core in reset while a program is streamed into instruction memory.
- Releases the core and gates its clock-enable, in free-run or single-step mode.
- Stops on a cycle limit, a halt PC or an abort, then streams all 32 architectural registers out over a valid/ready port.
- Sits between the top-level harness or debug link and the core's reset, enable, imem write and regfile debug-read ports.

Parameters:
IMEM_AW, 11, instruction-memory word-address width
CNT_W, 32, width of the cycle counter and the cycle limit
NREGS, 32, number of registers dumped

Ports:
clk_in  in  1  system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
load_go  in  1  pulse: enter LOAD from IDLE
start  in  1  pulse: enter RUN from IDLE
clear  in  1  pulse: DONE -> IDLE
abort  in  1  pulse: stop RUN
step_mode  in  1  1 = core advances only on step pulses
step  in  1  single-step pulse, used only when step_mode=1
max_cycles  in  CNT_W  cycle limit; 0 = unlimited
halt_en  in  1  enables the halt-PC compare
halt_pc  in  32  PC at which the core stops
cpu_pc  in  32  current PC from the core
ld_valid  in  1  load beat valid
ld_last  in  1  final load beat
ld_addr  in  IMEM_AW  imem word address of the beat
ld_data  in  32  instruction word
ld_ready  out  1  load beat accepted
imem_we  out  1  imem write strobe
imem_waddr  out  IMEM_AW  imem write address
imem_wdata  out  32  imem write data
cpu_rst  out  1  core reset, active-high
cpu_en  out  1  core clock-enable (PC/regfile/dmem update)
rf_raddr  out  5  regfile debug read address
rf_rdata  in  32  regfile debug read data (combinational)
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump beat accepted
dump_idx  out  5  register index of the current beat
dump_data  out  32  register value of the current beat
cycle_cnt  out  CNT_W  number of enabled core cycles in the last/current run
busy  out  1  state is not IDLE or DONE
done  out  1  state is DONE

Behaviour:
- Reset is asynchronous and active-high. It forces, immediately and from any state (mid-load, mid-run, mid-dump): state=IDLE, cpu_rst=1, cpu_en=0, ld_ready=0, imem_we=0, dump_valid=0, dump_idx=0, cycle_cnt=0, busy=0, done=0.
- States: IDLE, LOAD, RUN, DUMP, DONE.
- IDLE:
  - cpu_rst=1, cpu_en=0.
  - load_go -> LOAD; start -> RUN. If both are asserted, load_go wins.
  - Entering RUN clears cycle_cnt; cpu_rst drops in the first RUN cycle.
- LOAD:
  - ld_ready=1; cpu_rst stays 1.
  - imem_we = ld_valid; imem_waddr/imem_wdata are a combinational pass-through of ld_addr/ld_data (zero latency).
  - A beat with ld_valid & ld_last -> IDLE next cycle; that last beat is still written.
  - start/abort are ignored in LOAD.
- RUN:
  - cpu_rst=0.
  - Candidate enable: 1 in free-run; = step when step_mode=1.
  - Stop condition (combinational, evaluated every RUN cycle):
    - abort, OR
    - (halt_en & cpu_pc==halt_pc), OR
    - (max_cycles!=0 & cycle_cnt==max_cycles).
  - When the stop condition holds: cpu_en=0 that cycle, next state DUMP. The instruction at halt_pc is NOT executed. Simultaneous stop causes produce one transition.
  - Otherwise cpu_en = candidate enable, and cycle_cnt increments on every cycle with cpu_en=1. A run with limit N therefore executes exactly N instructions.
  - cycle_cnt saturates at all-ones and does not wrap.
- DUMP:
  - cpu_en=0 and cpu_rst=0, so register contents are preserved.
  - rf_raddr=dump_idx; dump_valid=1; dump_data=rf_rdata.
  - On dump_valid & dump_ready: dump_idx increments. Acceptance at dump_idx==NREGS-1 -> DONE and dump_idx returns to 0.
  - While dump_ready=0, dump_idx and dump_data are held stable.
  - abort is ignored in DUMP.
- DONE:
  - done=1, cpu_en=0, cpu_rst=0; cycle_cnt is held.
  - clear -> IDLE, which reasserts cpu_rst.
- All outputs are registered except the imem pass-through, cpu_en and dump_data.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum: IDLE=0, LOAD=1, RUN=2, DUMP=3, DONE=4, 3-bit encoding.
  - constants: NREGS, REG_AW=5, default IMEM_AW.
- One natural sub-module: run_stop_unit. It contains the cycle counter with saturation plus the stop-condition compare, and outputs stop and the counter value.

Test Plan:
- reset, load_go, 4 beats to addrs 0..3 (last on beat 3) -> 4 imem_we pulses with matching addr/data, ld_ready low afterwards, cpu_rst=1 throughout, state returns to IDLE.
- start, max_cycles=10, free-run -> cpu_en high for exactly 10 cycles, cycle_cnt=10, then dump_valid rises.
- halt_en=1, halt_pc=0x0040_0010, core PC incrementing by 4 from 0x0040_0000 -> cpu_en low when cpu_pc=0x0040_0010, cycle_cnt=4.
- step_mode=1, 3 step pulses spaced 5 cycles apart, then abort -> cycle_cnt=3, cpu_en high only on the 3 step cycles.
- Dump with dump_ready toggling 1/0 -> 32 beats with idx 0..31 in order, data stable while stalled, done=1 after beat 31; clear -> cpu_rst=1.
- Async reset mid-RUN with cycle_cnt=7 -> same cycle: cpu_rst=1, cpu_en=0, cycle_cnt=0, busy=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_ctrl_pkg
// Purpose : Shared state encoding and sizing constants for CPU run control.
// Rev     : 1.0
// ============================================================================
package cpu_ctrl_pkg;

  localparam int DEF_NREGS   = 32;
  localparam int REG_AW      = 5;
  localparam int DEF_IMEM_AW = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_stop.sv
`default_nettype none
// ============================================================================
// Module  : run_stop_unit
// Purpose : Saturating enabled-cycle counter and run stop-condition compare.
// Rev     : 1.0
// ============================================================================
module run_stop_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             abort,
  input  logic             halt_en,
  input  logic [31:0]      halt_pc,
  input  logic [31:0]      cpu_pc,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             stop,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_halt_hit;
  logic             w_limit_hit;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Halt compare is on the PC about to execute, so that instruction never runs.
  assign w_halt_hit  = halt_en && (cpu_pc == halt_pc);
  assign w_limit_hit = (max_cycles != '0) && (r_cnt == max_cycles);
  assign stop        = abort || w_halt_hit || w_limit_hit;
  assign cnt         = r_cnt;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_run_ctrl
// Purpose : Load / run / dump sequencer around the single-cycle CPU core.
// Rev     : 1.0
// ============================================================================
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int IMEM_AW = DEF_IMEM_AW,
  parameter int CNT_W   = 32,
  parameter int NREGS   = DEF_NREGS
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               load_go,
  input  logic               start,
  input  logic               clear,
  input  logic               abort,
  input  logic               step_mode,
  input  logic               step,
  input  logic [CNT_W-1:0]   max_cycles,
  input  logic               halt_en,
  input  logic [31:0]        halt_pc,
  input  logic [31:0]        cpu_pc,
  input  logic               ld_valid,
  input  logic               ld_last,
  input  logic [IMEM_AW-1:0] ld_addr,
  input  logic [31:0]        ld_data,
  output logic               ld_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_rst,
  output logic               cpu_en,
  output logic [REG_AW-1:0]  rf_raddr,
  input  logic [31:0]        rf_rdata,
  output logic               dump_valid,
  input  logic               dump_ready,
  output logic [REG_AW-1:0]  dump_idx,
  output logic [31:0]        dump_data,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic               busy,
  output logic               done
);

  localparam logic [REG_AW-1:0] C_LAST_IDX = REG_AW'(NREGS - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_ld_ready;
  logic              r_cpu_rst;
  logic              r_dump_valid;
  logic              r_busy;
  logic              r_done;
  logic [REG_AW-1:0] r_dump_idx;
  logic              w_stop;
  logic              w_cand_en;
  logic              w_cpu_en;
  logic              w_run_clr;
  logic              w_dump_acc;
  logic              w_dump_last;

  assign w_run_clr   = (r_state == ST_IDLE) && start && !load_go;
  assign w_cand_en   = step_mode ? step : 1'b1;
  assign w_cpu_en    = (r_state == ST_RUN) && !w_stop && w_cand_en;
  assign w_dump_acc  = (r_state == ST_DUMP) && dump_ready;
  assign w_dump_last = (r_dump_idx == C_LAST_IDX);

  run_stop_unit #(
    .CNT_W (CNT_W)
  ) u_stop (
    .clk_in     (clk_in),
    .reset      (reset),
    .clr        (w_run_clr),
    .en         (w_cpu_en),
    .abort      (abort),
    .halt_en    (halt_en),
    .halt_pc    (halt_pc),
    .cpu_pc     (cpu_pc),
    .max_cycles (max_cycles),
    .stop       (w_stop),
    .cnt        (cycle_cnt)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_go)    w_next = ST_LOAD;
        else if (start) w_next = ST_RUN;
      end
      ST_LOAD: if (ld_valid && ld_last)         w_next = ST_IDLE;
      ST_RUN:  if (w_stop)                      w_next = ST_DUMP;
      ST_DUMP: if (dump_ready && w_dump_last)   w_next = ST_DONE;
      ST_DONE: if (clear)                       w_next = ST_IDLE;
      default:                                  w_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track r_state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cpu_rst    <= 1'b1;
      r_ld_ready   <= 1'b0;
      r_dump_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dump_idx   <= '0;
    end else begin
      r_cpu_rst    <= (w_next == ST_IDLE) || (w_next == ST_LOAD);
      r_ld_ready   <= (w_next == ST_LOAD);
      r_dump_valid <= (w_next == ST_DUMP);
      r_busy       <= (w_next == ST_LOAD) || (w_next == ST_RUN) || (w_next == ST_DUMP);
      r_done       <= (w_next == ST_DONE);
      if (w_dump_acc) begin
        r_dump_idx <= w_dump_last ? '0 : r_dump_idx + REG_AW'(1);
      end
    end
  end

  assign ld_ready   = r_ld_ready;
  assign imem_we    = r_ld_ready && ld_valid;
  assign imem_waddr = ld_addr;
  assign imem_wdata = ld_data;
  assign cpu_rst    = r_cpu_rst;
  assign cpu_en     = w_cpu_en;
  assign rf_raddr   = r_dump_idx;
  assign dump_valid = r_dump_valid;
  assign dump_idx   = r_dump_idx;
  assign dump_data  = rf_rdata;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_run_ctrl
// Purpose : Scoreboard bench for cpu_run_ctrl with a simple core/regfile model.
// Rev     : 1.0
// ============================================================================
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int          IMEM_AW = 11;
  localparam int          CNT_W   = 32;
  localparam int          NR      = 32;
  localparam logic [31:0] PC_BASE = 32'h0040_0000;

  logic               clk_in = 1'b0;
  logic               reset  = 1'b1;
  logic               load_go, start, clear, abort, step_mode, step;
  logic [CNT_W-1:0]   max_cycles;
  logic               halt_en;
  logic [31:0]        halt_pc;
  logic [31:0]        cpu_pc;
  logic               ld_valid, ld_last;
  logic [IMEM_AW-1:0] ld_addr;
  logic [31:0]        ld_data;
  logic               ld_ready, imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;
  logic               cpu_rst, cpu_en;
  logic [4:0]         rf_raddr;
  logic [31:0]        rf_rdata;
  logic               dump_valid;
  logic               dump_ready = 1'b0;
  logic [4:0]         dump_idx;
  logic [31:0]        dump_data;
  logic [CNT_W-1:0]   cycle_cnt;
  logic               busy, done;

  cpu_run_ctrl #(.IMEM_AW(IMEM_AW), .CNT_W(CNT_W), .NREGS(NR)) dut (
    .clk_in(clk_in), .reset(reset), .load_go(load_go), .start(start),
    .clear(clear), .abort(abort), .step_mode(step_mode), .step(step),
    .max_cycles(max_cycles), .halt_en(halt_en), .halt_pc(halt_pc),
    .cpu_pc(cpu_pc), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .cycle_cnt(cycle_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  // Core model: PC advances by one word per enabled cycle; regfile is an array.
  logic [31:0] regs [NR];
  assign rf_rdata = regs[rf_raddr];
  always @(posedge clk_in) begin
    if (cpu_rst)     cpu_pc <= PC_BASE;
    else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
  end

  typedef struct packed { logic [IMEM_AW-1:0] addr; logic [31:0] data; } beat_t;
  typedef struct packed { logic [4:0] idx; logic [31:0] data; } dbeat_t;
  beat_t  imem_q [$];
  dbeat_t dump_q [$];
  int     run_q  [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_tb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Ready pattern: strict alternation or random, selectable per run.
  bit toggle_ready = 1'b1;
  initial begin
    forever begin
      @(posedge clk_in); #1;
      dump_ready = toggle_ready ? ~dump_ready : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  int          en_cnt = 0;
  logic        prev_dv = 1'b0, prev_stall = 1'b0;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;
  beat_t       mb;
  dbeat_t      md;
  int          me;
  always @(negedge clk_in) begin
    if (reset) begin
      en_cnt = 0; prev_dv = 1'b0; prev_stall = 1'b0;
    end else begin
      if (imem_we) begin
        chk("imem_cpu_rst", cpu_rst, 1);
        if (imem_q.size() == 0) chk("imem_unexpected_we", imem_we, 0);
        else begin
          mb = imem_q.pop_front();
          chk("imem_waddr", imem_waddr, mb.addr);
          chk("imem_wdata", imem_wdata, mb.data);
        end
      end
      if (cpu_en) begin
        en_cnt++;
        chk("en_cpu_rst", cpu_rst, 0);
      end
      if (dump_valid && !prev_dv) begin
        if (run_q.size() == 0) chk("run_unexpected_dump", dump_valid, 0);
        else begin
          me = run_q.pop_front();
          chk("run_cycle_cnt", cycle_cnt, 64'(me));
          chk("run_en_cycles", 64'(en_cnt), 64'(me));
        end
        en_cnt = 0;
      end
      if (prev_stall) begin
        chk("stall_idx", dump_idx, prev_idx);
        chk("stall_data", dump_data, prev_data);
      end
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) chk("dump_unexpected", dump_valid, 0);
        else begin
          md = dump_q.pop_front();
          chk("dump_idx", dump_idx, md.idx);
          chk("dump_data", dump_data, md.data);
        end
      end
      prev_stall = dump_valid && !dump_ready;
      prev_idx   = dump_idx;
      prev_data  = dump_data;
      prev_dv    = dump_valid;
    end
  end

  task automatic do_load(input int nb, input bit with_start);
    int i;
    @(posedge clk_in); #1 load_go = 1'b1; start = with_start;
    @(posedge clk_in); #1 load_go = 1'b0; start = 1'b0;
    chk("load_ready", ld_ready, 1);
    chk("load_busy", busy, 1);
    i = 0;
    while (i < nb) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      if (ld_valid) begin
        ld_addr = IMEM_AW'(i);
        ld_data = $urandom;
        ld_last = (i == nb - 1);
        imem_q.push_back('{addr: ld_addr, data: ld_data});
        i++;
      end else begin
        ld_addr = IMEM_AW'($urandom);
        ld_data = $urandom;
        ld_last = 1'($urandom);
      end
      @(posedge clk_in); #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("load_end_ready", ld_ready, 0);
    chk("load_end_busy", busy, 0);
    chk("load_end_cpu_rst", cpu_rst, 1);
    chk("load_all_written", 64'(imem_q.size()), 0);
  endtask

  // smode=0: abort after a enabled cycles; smode=1: a step pulses then abort.
  task automatic do_run(input bit smode, input int n, input bit hen, input int k,
                        input int a, input int gap);
    int e, g, t;
    for (int r = 0; r < NR; r++) regs[r] = $urandom;
    step_mode  = smode;
    max_cycles = CNT_W'(n);
    halt_en    = hen;
    halt_pc    = PC_BASE + 32'(4 * k);
    e = a;
    if (n != 0 && n < e) e = n;
    if (hen && k < e)    e = k;
    run_q.push_back(e);
    for (int r = 0; r < NR; r++) dump_q.push_back('{idx: 5'(r), data: regs[r]});
    @(posedge clk_in); #1 start = 1'b1;
    @(posedge clk_in); #1 start = 1'b0;
    if (!smode) begin
      repeat (a) @(posedge clk_in);
      #1 abort = 1'b1;
    end else begin
      for (int s = 0; s < a; s++) begin
        g = (gap < 0) ? int'($urandom_range(0, 4)) : gap;
        repeat (g) @(posedge clk_in);
        #1 step = 1'b1;
        @(posedge clk_in); #1 step = 1'b0;
      end
      repeat (1 + $urandom_range(0, 2)) @(posedge clk_in);
      #1 abort = 1'b1;
    end
    @(posedge clk_in); #1 abort = 1'b0;
    t = 0;
    while (!done && t < 2000) begin @(negedge clk_in); t++; end
    chk("run_reached_done", done, 1);
    if (!done) finish_tb();
    chk("done_busy", busy, 0);
    chk("done_cycle_cnt", cycle_cnt, 64'(e));
    chk("done_cpu_rst", cpu_rst, 0);
    chk("done_dump_valid", dump_valid, 0);
    chk("done_all_dumped", 64'(dump_q.size()), 0);
    @(posedge clk_in); #1 clear = 1'b1;
    @(posedge clk_in); #1 clear = 1'b0;
    chk("clear_cpu_rst", cpu_rst, 1);
    chk("clear_done", done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    finish_tb();
  end

  initial begin
    int t;
    load_go = 0; start = 0; clear = 0; abort = 0; step_mode = 0; step = 0;
    max_cycles = '0; halt_en = 0; halt_pc = '0;
    ld_valid = 0; ld_last = 0; ld_addr = '0; ld_data = '0;
    for (int r = 0; r < NR; r++) regs[r] = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_idx", dump_idx, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk_in) reset = 1'b0;

    do_load(4, 1'b1);
    do_run(1'b0, 10, 1'b0, 0, 30, 0);
    do_run(1'b0, 0, 1'b1, 4, 30, 0);
    do_run(1'b1, 0, 1'b0, 0, 3, 5);
    toggle_ready = 1'b0;
    do_load($urandom_range(1, 8), 1'b0);
    do_run(1'b0, 1, 1'b1, 1, 20, 0);
    do_run(1'b0, 0, 1'b1, 0, 20, 0);
    for (int r = 0; r < 8; r++) begin
      bit sm;
      sm = 1'($urandom_range(0, 1));
      do_run(sm, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
             sm ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 25)), -1);
    end

    // Asynchronous reset in the middle of a free run.
    step_mode = 1'b0; max_cycles = '0; halt_en = 1'b0;
    @(posedge clk_in); #1 start = 1'b1;
    @(posedge clk_in); #1 start = 1'b0;
    t = 0;
    while (cycle_cnt != 7 && t < 100) begin @(negedge clk_in); t++; end
    chk("arst_pre_cnt", cycle_cnt, 7);
    #2 reset = 1'b1;
    #1;
    chk("arst_cpu_rst", cpu_rst, 1);
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_cycle_cnt", cycle_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_dump_valid", dump_valid, 0);
    chk("arst_ld_ready", ld_ready, 0);
    @(negedge clk_in) reset = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("post_arst_busy", busy, 0);
    chk("left_run_q", 64'(run_q.size()), 0);
    chk("left_dump_q", 64'(dump_q.size()), 0);
    chk("left_imem_q", 64'(imem_q.size()), 0);
    finish_tb();
  end

endmodule
`default_nettype wire
